// File: rtl/nerv_lock_ctrl.sv
// nerv_lock_ctrl
//   Sequencing controller for the two-slot password memory and comparator
//   of the nerv lock. Slot 0 holds the enrolled key, slot 1 the attempt.
//   ENROLL/ENTER pulses become memory write/read cycles, the comparator
//   result is sampled, and the unlock window, failure count and timed
//   lockout are managed here.
//
//   Optional build macro: NERV_SCRUB_EN
//     When defined, every CMP is followed by one SCRUB cycle that writes 0
//     to slot 1 before OPEN/IDLE/LOCKED is entered.
//
// Ports
//   CLK            clock, rising edge
//   RESET          asynchronous active-high reset
//   DATA_IN        key or attempt value, sampled when a request is accepted
//   ENROLL         store DATA_IN as the key
//   ENTER          check DATA_IN against the key
//   MATCH          comparator result, valid in CMP
//   MEM_CS/WR/RD   memory chip select / write / read strobes
//   MEM_ADD        memory slot (0 = key, 1 = attempt)
//   MEM_DIN        memory write data
//   BUSY           state is not IDLE
//   UNLOCKED       high in OPEN
//   FAIL           one-cycle pulse on a rejected attempt or request
//   LOCKOUT        high in LOCKED
//   ENROLLED       a key has been stored since reset
//   ATTEMPTS_LEFT  remaining tries before lockout
module nerv_lock_ctrl #(
  parameter int WIDTH          = 16,
  parameter int MAX_TRIES      = 3,
  parameter int UNLOCK_CYCLES  = 100,
  parameter int LOCKOUT_CYCLES = 1000
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic [WIDTH-1:0]               DATA_IN,
  input  logic                           ENROLL,
  input  logic                           ENTER,
  input  logic                           MATCH,
  output logic                           MEM_CS,
  output logic                           MEM_WR,
  output logic                           MEM_RD,
  output logic                           MEM_ADD,
  output logic [WIDTH-1:0]               MEM_DIN,
  output logic                           BUSY,
  output logic                           UNLOCKED,
  output logic                           FAIL,
  output logic                           LOCKOUT,
  output logic                           ENROLLED,
  output logic [$clog2(MAX_TRIES+1)-1:0] ATTEMPTS_LEFT
);

  localparam int AW   = $clog2(MAX_TRIES + 1);
  localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [AW-1:0] TRIES_INIT = AW'(MAX_TRIES);
  localparam logic [TW-1:0] T_UNLOCK   = TW'(UNLOCK_CYCLES);
  localparam logic [TW-1:0] T_LOCK     = TW'(LOCKOUT_CYCLES);

`ifdef NERV_SCRUB_EN
  typedef enum logic [2:0] {
    S_IDLE, S_WR_KEY, S_WR_TRY, S_RD, S_CMP, S_OPEN, S_LOCKED, S_SCRUB
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_WR_KEY, S_WR_TRY, S_RD, S_CMP, S_OPEN, S_LOCKED
  } state_t;
`endif

  state_t            state, state_n, result;
  logic [WIDTH-1:0]  latch, latch_n;
  logic [TW-1:0]     timer, timer_n;
  logic [AW-1:0]     attempts_n;
  logic              enrolled_n;
  logic              fail_n;
  logic              cs_n, wr_n, rd_n, add_n;
  logic [WIDTH-1:0]  din_n;
`ifdef NERV_SCRUB_EN
  state_t            scrub_tgt, scrub_tgt_n;
`endif

  // Next-state and next-output logic. Every output is registered, so the
  // strobes are decoded from the state being entered rather than the
  // current one; that keeps them aligned with the state they describe.
  always_comb begin
    state_n    = state;
    latch_n    = latch;
    timer_n    = timer;
    attempts_n = ATTEMPTS_LEFT;
    enrolled_n = ENROLLED;
    fail_n     = 1'b0;
    result     = S_IDLE;
`ifdef NERV_SCRUB_EN
    scrub_tgt_n = scrub_tgt;
`endif

    case (state)
      S_IDLE: begin
        if (ENROLL) begin
          if (!ENROLLED) begin
            latch_n = DATA_IN;
            state_n = S_WR_KEY;
          end else begin
            fail_n = 1'b1;
          end
        end else if (ENTER) begin
          if (ENROLLED) begin
            latch_n = DATA_IN;
            state_n = S_WR_TRY;
          end else begin
            fail_n = 1'b1;
          end
        end
      end

      S_WR_KEY: begin
        enrolled_n = 1'b1;
        state_n    = S_IDLE;
      end

      S_WR_TRY: state_n = S_RD;

      S_RD: state_n = S_CMP;

      S_CMP: begin
        // The timer is loaded here even when SCRUB intervenes; SCRUB does
        // not touch it, so OPEN/LOCKED still see the full window.
        if (MATCH) begin
          attempts_n = TRIES_INIT;
          timer_n    = T_UNLOCK;
          result     = S_OPEN;
        end else begin
          fail_n = 1'b1;
          if (ATTEMPTS_LEFT <= AW'(1)) begin
            attempts_n = '0;
            timer_n    = T_LOCK;
            result     = S_LOCKED;
          end else begin
            attempts_n = ATTEMPTS_LEFT - AW'(1);
            result     = S_IDLE;
          end
        end
`ifdef NERV_SCRUB_EN
        scrub_tgt_n = result;
        state_n     = S_SCRUB;
`else
        state_n     = result;
`endif
      end

      S_OPEN: begin
        if (ENROLL) begin
          // Re-key while unlocked ends the window early.
          latch_n = DATA_IN;
          timer_n = '0;
          state_n = S_WR_KEY;
        end else if (timer <= TW'(1)) begin
          timer_n = '0;
          state_n = S_IDLE;
        end else begin
          timer_n = timer - TW'(1);
        end
      end

      S_LOCKED: begin
        if (timer <= TW'(1)) begin
          timer_n    = '0;
          attempts_n = TRIES_INIT;
          state_n    = S_IDLE;
        end else begin
          timer_n = timer - TW'(1);
        end
      end

`ifdef NERV_SCRUB_EN
      S_SCRUB: state_n = scrub_tgt;
`endif

      default: state_n = S_IDLE;
    endcase

    cs_n  = 1'b0;
    wr_n  = 1'b0;
    rd_n  = 1'b0;
    add_n = 1'b0;
    din_n = '0;
    case (state_n)
      S_WR_KEY: begin
        cs_n  = 1'b1;
        wr_n  = 1'b1;
        din_n = latch_n;
      end
      S_WR_TRY: begin
        cs_n  = 1'b1;
        wr_n  = 1'b1;
        add_n = 1'b1;
        din_n = latch_n;
      end
      S_RD: begin
        cs_n  = 1'b1;
        rd_n  = 1'b1;
        add_n = 1'b1;
      end
`ifdef NERV_SCRUB_EN
      S_SCRUB: begin
        cs_n  = 1'b1;
        wr_n  = 1'b1;
        add_n = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state         <= S_IDLE;
      latch         <= '0;
      timer         <= '0;
      ATTEMPTS_LEFT <= TRIES_INIT;
      ENROLLED      <= 1'b0;
      FAIL          <= 1'b0;
      MEM_CS        <= 1'b0;
      MEM_WR        <= 1'b0;
      MEM_RD        <= 1'b0;
      MEM_ADD       <= 1'b0;
      MEM_DIN       <= '0;
      BUSY          <= 1'b0;
      UNLOCKED      <= 1'b0;
      LOCKOUT       <= 1'b0;
`ifdef NERV_SCRUB_EN
      scrub_tgt     <= S_IDLE;
`endif
    end else begin
      state         <= state_n;
      latch         <= latch_n;
      timer         <= timer_n;
      ATTEMPTS_LEFT <= attempts_n;
      ENROLLED      <= enrolled_n;
      FAIL          <= fail_n;
      MEM_CS        <= cs_n;
      MEM_WR        <= wr_n;
      MEM_RD        <= rd_n;
      MEM_ADD       <= add_n;
      MEM_DIN       <= din_n;
      BUSY          <= (state_n != S_IDLE);
      UNLOCKED      <= (state_n == S_OPEN);
      LOCKOUT       <= (state_n == S_LOCKED);
`ifdef NERV_SCRUB_EN
      scrub_tgt     <= scrub_tgt_n;
`endif
    end
  end

endmodule

// File: tb/tb_nerv_lock_ctrl.sv
// Directed bench for nerv_lock_ctrl (WIDTH=16, MAX_TRIES=3,
// UNLOCK_CYCLES=100, LOCKOUT_CYCLES=1000). The bench plays the comparator:
// MATCH is driven only during the CMP cycle.
module tb_nerv_lock_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] DATA_IN;
  logic        ENROLL, ENTER, MATCH;
  logic        MEM_CS, MEM_WR, MEM_RD, MEM_ADD;
  logic [15:0] MEM_DIN;
  logic        BUSY, UNLOCKED, FAIL, LOCKOUT, ENROLLED;
  logic [1:0]  ATTEMPTS_LEFT;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  nerv_lock_ctrl #(
    .WIDTH(16), .MAX_TRIES(3), .UNLOCK_CYCLES(100), .LOCKOUT_CYCLES(1000)
  ) dut (
    .CLK(CLK), .RESET(RESET), .DATA_IN(DATA_IN), .ENROLL(ENROLL),
    .ENTER(ENTER), .MATCH(MATCH), .MEM_CS(MEM_CS), .MEM_WR(MEM_WR),
    .MEM_RD(MEM_RD), .MEM_ADD(MEM_ADD), .MEM_DIN(MEM_DIN), .BUSY(BUSY),
    .UNLOCKED(UNLOCKED), .FAIL(FAIL), .LOCKOUT(LOCKOUT),
    .ENROLLED(ENROLLED), .ATTEMPTS_LEFT(ATTEMPTS_LEFT)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled and inputs driven on the falling edge.
  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cs"},  MEM_CS, 0);
    check({tag, "_wr"},  MEM_WR, 0);
    check({tag, "_rd"},  MEM_RD, 0);
    check({tag, "_add"}, MEM_ADD, 0);
    check({tag, "_din"}, MEM_DIN, 0);
    check({tag, "_busy"}, BUSY, 0);
    check({tag, "_unl"}, UNLOCKED, 0);
    check({tag, "_fail"}, FAIL, 0);
    check({tag, "_lock"}, LOCKOUT, 0);
    check({tag, "_enr"}, ENROLLED, 0);
    check({tag, "_att"}, ATTEMPTS_LEFT, 3);
  endtask

  // Accept cycle, WR_TRY, RD, CMP, then returns in the result cycle
  // (after SCRUB when that build option is present).
  task automatic do_enter(input logic [15:0] d, input logic m);
    ENTER = 1'b1; DATA_IN = d;
    tick();
    ENTER = 1'b0; DATA_IN = ~d;
    check("wrtry_cs", MEM_CS, 1);
    check("wrtry_wr", MEM_WR, 1);
    check("wrtry_rd", MEM_RD, 0);
    check("wrtry_add", MEM_ADD, 1);
    check("wrtry_din", MEM_DIN, d);
    check("wrtry_busy", BUSY, 1);
    tick();
    check("rd_cs", MEM_CS, 1);
    check("rd_rd", MEM_RD, 1);
    check("rd_wr", MEM_WR, 0);
    tick();
    check("cmp_cs", MEM_CS, 0);
    check("cmp_busy", BUSY, 1);
    check("cmp_unl", UNLOCKED, 0);
    MATCH = m;
    tick();
    MATCH = 1'b0;
    check("res_fail", FAIL, !m);
`ifdef NERV_SCRUB_EN
    check("scrub_cs", MEM_CS, 1);
    check("scrub_wr", MEM_WR, 1);
    check("scrub_add", MEM_ADD, 1);
    check("scrub_din", MEM_DIN, 0);
    check("scrub_unl", UNLOCKED, 0);
    tick();
    check("scrub_fail_clr", FAIL, 0);
`endif
  endtask

  task automatic do_enroll(input logic [15:0] d);
    ENROLL = 1'b1; DATA_IN = d;
    tick();
    ENROLL = 1'b0;
    tick();
  endtask

  task automatic async_reset_pulse();
    #2 RESET = 1'b1;
    #1;
  endtask

  initial begin
    int cnt;
    logic bad;
    RESET = 1'b0; DATA_IN = '0; ENROLL = 1'b0; ENTER = 1'b0; MATCH = 1'b0;
    #1 RESET = 1'b1;
    tick(); tick();
    check_reset_vals("rst");
    RESET = 1'b0;
    tick();

    // ENTER before any enrollment: FAIL next cycle, no strobes
    ENTER = 1'b1; DATA_IN = 16'h1234;
    tick();
    ENTER = 1'b0;
    check("unenr_fail", FAIL, 1);
    check("unenr_cs", MEM_CS, 0);
    check("unenr_busy", BUSY, 0);
    check("unenr_att", ATTEMPTS_LEFT, 3);
    tick();
    check("unenr_fail_clr", FAIL, 0);

    // ENROLL and ENTER together: ENROLL wins
    ENROLL = 1'b1; ENTER = 1'b1; DATA_IN = 16'hBEEF;
    tick();
    ENROLL = 1'b0; ENTER = 1'b0; DATA_IN = 16'h0000;
    check("wrkey_cs", MEM_CS, 1);
    check("wrkey_wr", MEM_WR, 1);
    check("wrkey_add", MEM_ADD, 0);
    check("wrkey_din", MEM_DIN, 16'hBEEF);
    check("wrkey_enr", ENROLLED, 0);
    tick();
    check("enr_set", ENROLLED, 1);
    check("enr_cs", MEM_CS, 0);
    check("enr_busy", BUSY, 0);
    tick();
    check("enter_dropped_cs", MEM_CS, 0);
    check("enter_dropped_busy", BUSY, 0);

    // Second ENROLL once enrolled is rejected
    ENROLL = 1'b1; DATA_IN = 16'h5555;
    tick();
    ENROLL = 1'b0;
    check("reenr_fail", FAIL, 1);
    check("reenr_cs", MEM_CS, 0);
    tick();
    check("reenr_fail_clr", FAIL, 0);

    // Matching attempt: 100-cycle unlock window
    do_enter(16'hBEEF, 1'b1);
    check("open_att", ATTEMPTS_LEFT, 3);
    cnt = 0;
    while (UNLOCKED === 1'b1 && cnt < 300) begin
      cnt++;
      tick();
    end
    check("open_len", cnt, 100);
    check("open_end_busy", BUSY, 0);

    // ENTER ignored in OPEN, ENROLL re-keys
    do_enter(16'hBEEF, 1'b1);
    tick(); tick();
    ENTER = 1'b1; DATA_IN = 16'h7777;
    tick();
    ENTER = 1'b0;
    check("open_enter_cs", MEM_CS, 0);
    check("open_enter_unl", UNLOCKED, 1);
    check("open_enter_fail", FAIL, 0);
    ENROLL = 1'b1; DATA_IN = 16'h0F0F;
    tick();
    ENROLL = 1'b0;
    check("rekey_unl", UNLOCKED, 0);
    check("rekey_cs", MEM_CS, 1);
    check("rekey_wr", MEM_WR, 1);
    check("rekey_add", MEM_ADD, 0);
    check("rekey_din", MEM_DIN, 16'h0F0F);
    tick();
    check("rekey_busy", BUSY, 0);
    check("rekey_enr", ENROLLED, 1);

    // Three failures: countdown then lockout
    for (int i = 0; i < 3; i++) begin
      do_enter(16'h1234, 1'b0);
      check("fail_att", ATTEMPTS_LEFT, 2 - i);
      check("fail_lock", LOCKOUT, (i == 2));
      check("fail_unl", UNLOCKED, 0);
    end
    cnt = 0;
    bad = 1'b0;
    while (LOCKOUT === 1'b1 && cnt < 2000) begin
      if (cnt == 10) begin
        ENTER = 1'b1; ENROLL = 1'b1; DATA_IN = 16'hBEEF;
      end else begin
        ENTER = 1'b0; ENROLL = 1'b0;
      end
      if (cnt > 0 && (FAIL !== 1'b0 || MEM_CS !== 1'b0)) bad = 1'b1;
      cnt++;
      tick();
    end
    ENTER = 1'b0; ENROLL = 1'b0;
    check("lock_len", cnt, 1000);
    check("lock_ignored", bad, 0);
    check("lock_end_att", ATTEMPTS_LEFT, 3);
    check("lock_end_busy", BUSY, 0);

    // Asynchronous reset during OPEN
    do_enter(16'h0F0F, 1'b1);
    tick();
    check("pre_rst_unl", UNLOCKED, 1);
    async_reset_pulse();
    check_reset_vals("rst_open");
    tick();
    RESET = 1'b0;
    tick();

    // Asynchronous reset during LOCKED
    do_enroll(16'hCAFE);
    check("enr2", ENROLLED, 1);
    for (int i = 0; i < 3; i++) do_enter(16'h4321, 1'b0);
    tick(); tick();
    check("pre_rst_lock", LOCKOUT, 1);
    check("pre_rst_att", ATTEMPTS_LEFT, 0);
    async_reset_pulse();
    check_reset_vals("rst_lock");
    tick();
    RESET = 1'b0;
    tick();
    ENTER = 1'b1; DATA_IN = 16'hCAFE;
    tick();
    ENTER = 1'b0;
    check("post_rst_unenr_fail", FAIL, 1);
    check("post_rst_cs", MEM_CS, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
